if_parcel_aligner: RTL and testbench
====================================

Name: if_parcel_aligner

Overview:
- Halfword-alignment engine at the back of the fetch (IF) stage; feeds the IF→PD pipeline register.
- Consumes 32-bit fetch words and tracks whether the next instruction starts at halfword 0 or halfword 1.
- Buffers a leftover upper halfword and emits the IF→PD selection set: raw_parcel, sel_compressed, sel_spanning, sel_nop, effective_instr, spanning_instr, PC, link address.
- PD performs the decompression itself; this block only selects and aligns.

Parameters:
- XLEN, 32, address/PC width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_stall  in  1  pipeline stall; hold all state and outputs.
- i_redirect_valid  in  1  branch/trap/MRET redirect this cycle.
- i_redirect_pc  in  XLEN  redirect target (halfword aligned, bit0=0).
- i_fetch_valid  in  1  fetch word available.
- i_fetch_word  in  32  fetched word (little-endian: halfword0=[15:0]).
- i_fetch_pc  in  XLEN  word-aligned address of i_fetch_word.
- o_fetch_ready  out  1  word consumed this cycle (combinational).
- o_raw_parcel  out  16  halfword for the compressed path.
- o_sel_compressed  out  1  PD uses the decompressed raw_parcel.
- o_sel_spanning  out  1  PD uses o_spanning_instr.
- o_sel_nop  out  1  bubble.
- o_effective_instr  out  32  aligned 32-bit instruction.
- o_spanning_instr  out  32  {new_word[15:0], held_half}.
- o_program_counter  out  XLEN  PC of the emitted instruction.
- o_link_address  out  XLEN  PC+2 if compressed, else PC+4.

Behaviour:
- All o_* except o_fetch_ready are registered; one-cycle latency from consumption to output.
- Reset values: sel_nop=1; all other sel_* =0; instr/parcel/PC/link =0; state=ALIGN0; hold_valid=0.
- Compressed test: parcel[1:0] != 2'b11.
- Internal state: state ∈ {ALIGN0, ALIGN1_WAIT, UPPER}, hold_half[15:0], hold_pc[XLEN-1:0].
- Priority: reset > redirect > stall > normal.
- Redirect:
  - Outputs sel_nop=1; o_fetch_ready=0; buffer discarded.
  - state ← i_redirect_pc[1] ? ALIGN1_WAIT : ALIGN0.
  - Redirect overrides a simultaneous stall.
- Stall: o_fetch_ready=0; state and all outputs hold.
- ALIGN0:
  - No valid fetch → emit NOP, stay.
  - Valid, word[1:0]!=11:
    - Consume; emit sel_compressed, raw_parcel=word[15:0], PC=fetch_pc, link=+2.
    - hold_half=word[31:16], hold_pc=fetch_pc+2; → UPPER.
  - Valid, 32-bit:
    - Consume; emit effective_instr=word, PC=fetch_pc, link=+4; stay.
- UPPER:
  - hold_half compressed:
    - o_fetch_ready=0; emit sel_compressed, raw_parcel=hold_half, PC=hold_pc, link=+2; → ALIGN0.
  - hold_half 32-bit, no valid fetch → emit NOP, stay.
  - hold_half 32-bit, valid fetch:
    - Consume; emit sel_spanning, spanning_instr={word[15:0],hold_half}, PC=hold_pc, link=+4.
    - hold_half=word[31:16], hold_pc=fetch_pc+2; stay UPPER.
- ALIGN1_WAIT:
  - Valid fetch: consume; hold_half=word[31:16], hold_pc=fetch_pc+2; emit NOP; → UPPER.
  - This is a one-bubble cost, accepted.
- Output encoding:
  - Exactly one of sel_nop/sel_compressed/sel_spanning, or none (which selects aligned effective_instr).
  - Unselected data fields hold last value; no need to zero them.
- PC arithmetic wraps modulo 2^XLEN.
- Link address always equals PC+2 for compressed and PC+4 otherwise, including the spanning case.

Optional Feature:
- Macro: IF_ALIGNER_PERF_CNT_EN.
- With it:
  - Adds outputs o_perf_spanning_cnt[31:0] and o_perf_bubble_cnt[31:0].
  - Counters increment on each emitted spanning instruction / each emitted sel_nop that is not caused by reset, redirect, or stall.
  - Counters saturate at 32'hFFFF_FFFF; reset to 0.
- Without it: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- riscv_pkg:
  - aligner_state_e enum (ALIGN0, ALIGN1_WAIT, UPPER).
  - NOP constant (existing).
  - is_compressed_parcel function (bits[1:0] != 2'b11).
  - Fields of from_if_to_pd_t driven here.
- No sub-module required; a single module of roughly 200 lines.

Test Plan:
- Reset, then words 0x00000013 @0x0, 0x00100093 @0x4 → effective_instr in order, PC 0x0/0x4, link 0x4/0x8; fetch_ready=1 each cycle.
- Word 0x45014501 @0x0 (two c.li) → cycle1: compressed raw_parcel 0x4501, PC 0x0; cycle2: compressed 0x4501, PC 0x2, fetch_ready=0 on that cycle.
- Word 0x00134501 @0x0 then 0x00000093 @0x4:
  - compressed, PC 0x0;
  - then spanning_instr=0x00930013... check bits {0x0093,0x0013}, PC 0x2, link 0x6;
  - state stays UPPER with hold_half=0x0000.
- Spanning pending in UPPER, fetch_valid=0 for 3 cycles → three NOPs, no state change; word arrives → spanning emitted.
- Redirect to 0x102 with stall asserted → NOP emitted, state ALIGN1_WAIT; next word @0x100 = 0x4501xxxx → NOP, then compressed 0x4501 PC 0x102.
- Stall for 2 cycles mid-stream → outputs and hold regs unchanged, fetch_ready=0; release resumes identically.
- With IF_ALIGNER_PERF_CNT_EN: after the spanning case above → spanning_cnt=1; bubble_cnt counts only the starvation NOPs.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types: aligner state, NOP, and the IF->PD bundle.
package riscv_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ALIGN0,
        ALIGN1_WAIT,
        UPPER
    } aligner_state_e;

    typedef struct packed {
        logic [15:0] raw_parcel;
        logic        sel_compressed;
        logic        sel_spanning;
        logic        sel_nop;
        logic [31:0] effective_instr;
        logic [31:0] spanning_instr;
    } from_if_to_pd_t;

    function automatic logic is_compressed_parcel(input logic [15:0] p);
        return p[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/if_parcel_aligner.sv
// Halfword alignment at the back of IF, feeding the IF->PD register.
// Optional perf counters: define IF_ALIGNER_PERF_CNT_EN.
module if_parcel_aligner
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_fetch_valid,
    input  logic [31:0]     i_fetch_word,
    input  logic [XLEN-1:0] i_fetch_pc,
    output logic            o_fetch_ready,
    output logic [15:0]     o_raw_parcel,
    output logic            o_sel_compressed,
    output logic            o_sel_spanning,
    output logic            o_sel_nop,
    output logic [31:0]     o_effective_instr,
    output logic [31:0]     o_spanning_instr,
    output logic [XLEN-1:0] o_program_counter,
    output logic [XLEN-1:0] o_link_address
`ifdef IF_ALIGNER_PERF_CNT_EN
    ,
    output logic [31:0]     o_perf_spanning_cnt,
    output logic [31:0]     o_perf_bubble_cnt
`endif
);

    localparam logic [XLEN-1:0] TWO  = XLEN'(2);
    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    aligner_state_e  state_q, state_d;
    logic [15:0]     hold_half_q, hold_half_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    from_if_to_pd_t  out_q, out_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] link_q, link_d;
    logic            ready;

    always_comb begin
        state_d     = state_q;
        hold_half_d = hold_half_q;
        hold_pc_d   = hold_pc_q;
        out_d       = out_q;
        pc_d        = pc_q;
        link_d      = link_q;
        ready       = 1'b0;
        if (i_redirect_valid) begin
            out_d.sel_nop        = 1'b1;
            out_d.sel_compressed = 1'b0;
            out_d.sel_spanning   = 1'b0;
            state_d = i_redirect_pc[1] ? ALIGN1_WAIT : ALIGN0;
        end else if (!i_stall) begin
            out_d.sel_nop        = 1'b0;
            out_d.sel_compressed = 1'b0;
            out_d.sel_spanning   = 1'b0;
            unique case (state_q)
                ALIGN0: begin
                    if (!i_fetch_valid) begin
                        out_d.sel_nop = 1'b1;
                    end else if (is_compressed_parcel(i_fetch_word[15:0])) begin
                        ready                = 1'b1;
                        out_d.sel_compressed = 1'b1;
                        out_d.raw_parcel     = i_fetch_word[15:0];
                        pc_d                 = i_fetch_pc;
                        link_d               = i_fetch_pc + TWO;
                        hold_half_d          = i_fetch_word[31:16];
                        hold_pc_d            = i_fetch_pc + TWO;
                        state_d              = UPPER;
                    end else begin
                        ready                 = 1'b1;
                        out_d.effective_instr = i_fetch_word;
                        pc_d                  = i_fetch_pc;
                        link_d                = i_fetch_pc + FOUR;
                    end
                end
                // The held upper half is either a whole RVC op or the low half of a spanning op.
                UPPER: begin
                    if (is_compressed_parcel(hold_half_q)) begin
                        out_d.sel_compressed = 1'b1;
                        out_d.raw_parcel     = hold_half_q;
                        pc_d                 = hold_pc_q;
                        link_d               = hold_pc_q + TWO;
                        state_d              = ALIGN0;
                    end else if (!i_fetch_valid) begin
                        out_d.sel_nop = 1'b1;
                    end else begin
                        ready                = 1'b1;
                        out_d.sel_spanning   = 1'b1;
                        out_d.spanning_instr = {i_fetch_word[15:0], hold_half_q};
                        pc_d                 = hold_pc_q;
                        link_d               = hold_pc_q + FOUR;
                        hold_half_d          = i_fetch_word[31:16];
                        hold_pc_d            = i_fetch_pc + TWO;
                    end
                end
                ALIGN1_WAIT: begin
                    out_d.sel_nop = 1'b1;
                    if (i_fetch_valid) begin
                        ready       = 1'b1;
                        hold_half_d = i_fetch_word[31:16];
                        hold_pc_d   = i_fetch_pc + TWO;
                        state_d     = UPPER;
                    end
                end
                default: begin
                    out_d.sel_nop = 1'b1;
                    state_d       = ALIGN0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ALIGN0;
            hold_half_q   <= '0;
            hold_pc_q     <= '0;
            out_q         <= '0;
            out_q.sel_nop <= 1'b1;
            pc_q          <= '0;
            link_q        <= '0;
        end else begin
            state_q     <= state_d;
            hold_half_q <= hold_half_d;
            hold_pc_q   <= hold_pc_d;
            out_q       <= out_d;
            pc_q        <= pc_d;
            link_q      <= link_d;
        end
    end

    assign o_fetch_ready     = ready & ~i_rst;
    assign o_raw_parcel      = out_q.raw_parcel;
    assign o_sel_compressed  = out_q.sel_compressed;
    assign o_sel_spanning    = out_q.sel_spanning;
    assign o_sel_nop         = out_q.sel_nop;
    assign o_effective_instr = out_q.effective_instr;
    assign o_spanning_instr  = out_q.spanning_instr;
    assign o_program_counter = pc_q;
    assign o_link_address    = link_q;

`ifdef IF_ALIGNER_PERF_CNT_EN
    logic        normal_cyc;
    logic [31:0] span_cnt_q, bub_cnt_q;

    // Only bubbles from the normal path count; redirect and stall are excluded.
    assign normal_cyc = ~i_redirect_valid & ~i_stall;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            span_cnt_q <= '0;
            bub_cnt_q  <= '0;
        end else if (normal_cyc) begin
            if (out_d.sel_spanning && span_cnt_q != 32'hFFFF_FFFF)
                span_cnt_q <= span_cnt_q + 32'd1;
            if (out_d.sel_nop && bub_cnt_q != 32'hFFFF_FFFF)
                bub_cnt_q <= bub_cnt_q + 32'd1;
        end
    end

    assign o_perf_spanning_cnt = span_cnt_q;
    assign o_perf_bubble_cnt   = bub_cnt_q;
`else
    // No performance state exists in this build.
`endif

endmodule

// File: tb/tb_if_parcel_aligner.sv
// Scoreboard bench for if_parcel_aligner: expected IF->PD outputs queued per step.
module tb_if_parcel_aligner;

    localparam int K_ALN = 0;
    localparam int K_CMP = 1;
    localparam int K_SPN = 2;
    localparam int K_NOP = 3;

    typedef struct {
        int          kind;
        logic [31:0] data;
        logic [31:0] pc;
        logic [31:0] link;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        fv;
    logic [31:0] fword;
    logic [31:0] fpc;
    logic        fetch_ready;
    logic [15:0] raw_parcel;
    logic        sel_c, sel_s, sel_n;
    logic [31:0] eff_instr, span_instr, prog_cnt, link_addr;
`ifdef IF_ALIGNER_PERF_CNT_EN
    logic [31:0] perf_span, perf_bub;
`endif

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    if_parcel_aligner #(.XLEN(32)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_stall          (stall),
        .i_redirect_valid (rv),
        .i_redirect_pc    (rpc),
        .i_fetch_valid    (fv),
        .i_fetch_word     (fword),
        .i_fetch_pc       (fpc),
        .o_fetch_ready    (fetch_ready),
        .o_raw_parcel     (raw_parcel),
        .o_sel_compressed (sel_c),
        .o_sel_spanning   (sel_s),
        .o_sel_nop        (sel_n),
        .o_effective_instr(eff_instr),
        .o_spanning_instr (span_instr),
        .o_program_counter(prog_cnt),
        .o_link_address   (link_addr)
`ifdef IF_ALIGNER_PERF_CNT_EN
        ,
        .o_perf_spanning_cnt(perf_span),
        .o_perf_bubble_cnt  (perf_bub)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input int k, input logic [31:0] d,
                                input logic [31:0] pc, input logic [31:0] lk);
        exp_t e;
        e.kind = k;
        e.data = d;
        e.pc   = pc;
        e.link = lk;
        return e;
    endfunction

    task automatic step(input string tag, input logic r, input logic [31:0] rp,
                        input logic st, input logic v, input logic [31:0] w,
                        input logic [31:0] p, input logic exp_rdy, input exp_t e);
        exp_t o;
        @(negedge clk);
        rst = 1'b0; rv = r; rpc = rp; stall = st;
        fv = v; fword = w; fpc = p;
        #1;
        chk({tag, ".ready"}, 32'(fetch_ready), 32'(exp_rdy));
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            o = sb.pop_front();
            chk({tag, ".nop"}, 32'(sel_n), 32'(o.kind == K_NOP));
            chk({tag, ".cmp"}, 32'(sel_c), 32'(o.kind == K_CMP));
            chk({tag, ".spn"}, 32'(sel_s), 32'(o.kind == K_SPN));
            if (o.kind != K_NOP) begin
                if (o.kind == K_CMP) chk({tag, ".parcel"}, 32'(raw_parcel), o.data);
                if (o.kind == K_SPN) chk({tag, ".span"}, span_instr, o.data);
                if (o.kind == K_ALN) chk({tag, ".instr"}, eff_instr, o.data);
                chk({tag, ".pc"}, prog_cnt, o.pc);
                chk({tag, ".link"}, link_addr, o.link);
            end
        end
    endtask

    initial begin
        exp_t sp;
        rst = 1'b1; stall = 1'b0; rv = 1'b0; rpc = '0;
        fv = 1'b0; fword = '0; fpc = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.nop", 32'(sel_n), 32'd1);
        chk("rst.cmp", 32'(sel_c), 32'd0);
        chk("rst.spn", 32'(sel_s), 32'd0);
        chk("rst.instr", eff_instr, 32'd0);
        chk("rst.parcel", 32'(raw_parcel), 32'd0);
        chk("rst.pc", prog_cnt, 32'd0);
        chk("rst.link", link_addr, 32'd0);
        chk("rst.ready", 32'(fetch_ready), 32'd0);

        step("a0", 0, 0, 0, 1, 32'h0000_0013, 32'h0, 1, mk(K_ALN, 32'h0000_0013, 32'h0, 32'h4));
        step("a1", 0, 0, 0, 1, 32'h0010_0093, 32'h4, 1, mk(K_ALN, 32'h0010_0093, 32'h4, 32'h8));

        step("c0", 0, 0, 0, 1, 32'h4501_4501, 32'h0, 1, mk(K_CMP, 32'h4501, 32'h0, 32'h2));
        step("c1", 0, 0, 0, 1, 32'h0000_0013, 32'h4, 0, mk(K_CMP, 32'h4501, 32'h2, 32'h4));
        step("c2", 0, 0, 0, 1, 32'h0000_0013, 32'h4, 1, mk(K_ALN, 32'h0000_0013, 32'h4, 32'h8));

        step("s0", 0, 0, 0, 1, 32'h0013_4501, 32'h0, 1, mk(K_CMP, 32'h4501, 32'h0, 32'h2));
        step("s1", 0, 0, 0, 1, 32'h0000_0093, 32'h4, 1, mk(K_SPN, 32'h0093_0013, 32'h2, 32'h6));
        step("s2", 0, 0, 0, 0, 32'h0, 32'h0, 0, mk(K_CMP, 32'h0000, 32'h6, 32'h8));

        step("w0", 0, 0, 0, 1, 32'h0013_8001, 32'h10, 1, mk(K_CMP, 32'h8001, 32'h10, 32'h12));
        for (int i = 0; i < 3; i++)
            step("wnop", 0, 0, 0, 0, 32'h0, 32'h0, 0, mk(K_NOP, 0, 0, 0));
        sp = mk(K_SPN, 32'h0093_0013, 32'h12, 32'h16);
        step("w1", 0, 0, 0, 1, 32'h0000_0093, 32'h14, 1, sp);

        step("st0", 0, 0, 1, 1, 32'h4501_4501, 32'h18, 0, sp);
        step("st1", 0, 0, 1, 1, 32'h4501_4501, 32'h18, 0, sp);
        step("st2", 0, 0, 0, 0, 32'h0, 32'h0, 0, mk(K_CMP, 32'h0000, 32'h16, 32'h18));

        step("r0", 1, 32'h102, 1, 1, 32'h0000_0013, 32'h0, 0, mk(K_NOP, 0, 0, 0));
        step("r1", 0, 0, 0, 1, 32'h4501_0013, 32'h100, 1, mk(K_NOP, 0, 0, 0));
        step("r2", 0, 0, 0, 0, 32'h0, 32'h0, 0, mk(K_CMP, 32'h4501, 32'h102, 32'h104));

        step("e0", 1, 32'h200, 0, 1, 32'h0000_0013, 32'h0, 0, mk(K_NOP, 0, 0, 0));
        step("e1", 0, 0, 0, 1, 32'h0010_0093, 32'h200, 1, mk(K_ALN, 32'h0010_0093, 32'h200, 32'h204));

        step("x0", 0, 0, 0, 1, 32'h0000_0013, 32'hFFFF_FFFC, 1,
             mk(K_ALN, 32'h0000_0013, 32'hFFFF_FFFC, 32'h0));
        step("x1", 0, 0, 0, 1, 32'h0013_4501, 32'hFFFF_FFFC, 1,
             mk(K_CMP, 32'h4501, 32'hFFFF_FFFC, 32'hFFFF_FFFE));
        step("x2", 0, 0, 0, 1, 32'h0000_0093, 32'h0, 1,
             mk(K_SPN, 32'h0093_0013, 32'hFFFF_FFFE, 32'h2));

        step("d0", 1, 32'h300, 0, 0, 32'h0, 32'h0, 0, mk(K_NOP, 0, 0, 0));
        step("d1", 0, 0, 0, 1, 32'h0000_0013, 32'h300, 1, mk(K_ALN, 32'h0000_0013, 32'h300, 32'h304));
        step("d2", 0, 0, 0, 0, 32'h0, 32'h0, 0, mk(K_NOP, 0, 0, 0));

`ifdef IF_ALIGNER_PERF_CNT_EN
        chk("perf.span", perf_span, 32'd3);
        chk("perf.bub", perf_bub, 32'd5);
`endif
        chk("sb.drain", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
